// File: rtl/ltc2174_pkg.sv
// Shared constants, FSM state type and word unpack/convert helper for the
// LTC2174 pattern-check stage.
package ltc2174_pkg;

  localparam int ADC_BITS  = 14;
  localparam int WORD_BITS = 16;
  localparam int PAD_BITS  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Drops the pad bits and, for offset-binary ADC output, flips the MSB to
  // obtain two's complement.
  function automatic logic [ADC_BITS-1:0] unpack_conv(
    input logic [WORD_BITS-1:0] word,
    input logic                 twoscomp
  );
    logic [ADC_BITS-1:0] raw;
    raw = word[WORD_BITS-1:PAD_BITS];
    return twoscomp ? raw : {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/ltc2174_chan_check.sv
// One ADC channel: registered sign-extended sample plus the pattern compare
// and saturating mismatch counter driven by the top-level FSM strobes.
module ltc2174_chan_check
  import ltc2174_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] word,
  input  logic                 twoscomp,
  input  logic [ADC_BITS-1:0]  testpattern,
  input  logic                 clear,
  input  logic                 enable,
  output logic [WORD_BITS-1:0] sample,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_cnt
);

  logic [ADC_BITS-1:0] conv;

  // The check uses the word as transmitted, so twoscomp has no influence.
  always_comb begin
    conv     = unpack_conv(word, twoscomp);
    mismatch = (word[WORD_BITS-1:PAD_BITS] != testpattern);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample  <= '0;
      err_cnt <= '0;
    end else begin
      sample <= {{(WORD_BITS-ADC_BITS){conv[ADC_BITS-1]}}, conv};
      if (clear)
        err_cnt <= '0;
      else if (enable && mismatch && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ltc2174_pattern_check.sv
// LTC2174 post-deserializer stage: sample unpack/convert for the DSP path and
// a start-triggered per-channel test-pattern checker.
module ltc2174_pattern_check
  import ltc2174_pkg::*;
#(
  parameter int CHAN       = 4,
  parameter int SETTLE_CYC = 256,
  parameter int DWELL_CYC  = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHAN*16-1:0]      adc_data,
  input  logic                    twoscomp,
  input  logic [13:0]             testpattern,
  input  logic                    start,
  output logic [CHAN*16-1:0]      sample_out,
  output logic                    sample_vld,
  output logic                    busy,
  output logic                    done,
  output logic [CHAN-1:0]         pass,
  output logic [CHAN*CNT_W-1:0]   err_cnt
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DWELL_LAST  = 16'(DWELL_CYC - 1);

  state_t          state;
  logic [15:0]     cnt;
  logic            start_d;
  logic            start_rise;
  logic            clear;
  logic            enable;
  logic [CHAN-1:0] mismatch;
  logic [CHAN-1:0] pass_next;

  always_comb begin
    start_rise = start & ~start_d;
    clear      = start_rise && ((state == IDLE) || (state == DONE));
    enable     = (state == CHECK);
    // The final CHECK cycle's mismatch lands in err_cnt on the same edge that
    // registers pass, so it is folded in here.
    pass_next = '0;
    for (int unsigned k = 0; k < CHAN; k++)
      pass_next[k] = (err_cnt[k*CNT_W +: CNT_W] == '0) && !mismatch[k];
  end

  for (genvar k = 0; k < CHAN; k++) begin : g_chan
    ltc2174_chan_check #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .word        (adc_data[k*16 +: 16]),
      .twoscomp    (twoscomp),
      .testpattern (testpattern),
      .clear       (clear),
      .enable      (enable),
      .sample      (sample_out[k*16 +: 16]),
      .mismatch    (mismatch[k]),
      .err_cnt     (err_cnt[k*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      start_d    <= 1'b0;
      sample_vld <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= '0;
    end else begin
      start_d    <= start;
      sample_vld <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            state <= SETTLE;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= '0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= pass_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2174_pattern_check.sv
// Bench for ltc2174_pattern_check: two instances (16-bit and 4-bit counters)
// share stimulus and are checked every cycle against a launch-time model.
module tb_ltc2174_pattern_check;

  localparam int S = 4;
  localparam logic [15:0] GOOD     = 16'hA968; // raw 14'h2A5A
  localparam logic [15:0] PAD_GOOD = 16'hA96B; // same raw, pad bits set
  localparam logic [15:0] BAD0     = 16'hA96C; // raw 14'h2A5B

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] adc_data;
  logic        twoscomp;
  logic [13:0] testpattern;
  logic        start;

  logic [63:0] sample_a, sample_b;
  logic        vld_a, vld_b, busy_a, busy_b, done_a, done_b;
  logic [3:0]  pass_a, pass_b;
  logic [63:0] err_a;
  logic [15:0] err_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ltc2174_pattern_check #(
    .CHAN(4), .SETTLE_CYC(S), .DWELL_CYC(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .twoscomp(twoscomp),
    .testpattern(testpattern), .start(start), .sample_out(sample_a),
    .sample_vld(vld_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a)
  );

  ltc2174_pattern_check #(
    .CHAN(4), .SETTLE_CYC(S), .DWELL_CYC(20), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .adc_data(adc_data), .twoscomp(twoscomp),
    .testpattern(testpattern), .start(start), .sample_out(sample_b),
    .sample_vld(vld_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run launched at edge eL is in SETTLE/CHECK after edges eL..eL+S+D-1,
  // compares the data presented at edges eL+S+1..eL+S+D, and is done afterwards.
  initial begin : model_compare
    int D[2];
    int W[2];
    bit launched[2];
    int eL[2];
    int cnt[2][4];
    bit sp;
    bit rise;
    int e;
    logic [63:0] exp_sample;
    bit exp_vld;
    D = '{16, 20};
    W = '{16, 4};
    launched = '{0, 0};
    eL = '{0, 0};
    sp = 0;
    e = 0;
    exp_sample = '0;
    exp_vld = 0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) cnt[i][k] = 0;
    forever begin
      @(posedge clk);
      e++;
      if (rst !== 1'b1) begin
        sp = 0;
        exp_vld = 0;
        exp_sample = '0;
        for (int i = 0; i < 2; i++) begin
          launched[i] = 0;
          for (int k = 0; k < 4; k++) cnt[i][k] = 0;
        end
      end else begin
        rise = start && !sp;
        for (int i = 0; i < 2; i++) begin
          int p;
          bit busy_before;
          p = e - eL[i];
          busy_before = launched[i] && p >= 1 && p <= S + D[i];
          if (rise && !busy_before) begin
            launched[i] = 1;
            eL[i] = e;
            for (int k = 0; k < 4; k++) cnt[i][k] = 0;
          end else if (launched[i] && p >= S + 1 && p <= S + D[i]) begin
            for (int k = 0; k < 4; k++)
              if (int'(adc_data[k*16 +: 16]) / 4 != int'(testpattern)) cnt[i][k]++;
          end
        end
        for (int k = 0; k < 4; k++) begin
          int raw, v;
          raw = int'(adc_data[k*16 +: 16]) / 4;
          if (twoscomp) v = (raw >= 8192) ? raw - 16384 : raw;
          else          v = raw - 8192;
          exp_sample[k*16 +: 16] = 16'(v);
        end
        exp_vld = 1;
        sp = start;
      end
      #1;
      check("sample_out", sample_a, exp_sample);
      check("sample_vld", {63'b0, vld_a}, {63'b0, exp_vld});
      check("sample_out_sat", sample_b, exp_sample);
      for (int i = 0; i < 2; i++) begin
        int q, sat;
        bit eb, ed;
        logic [3:0] ep, ap;
        logic [63:0] ee, ae;
        q = e - eL[i];
        eb = launched[i] && q < S + D[i];
        ed = launched[i] && q >= S + D[i];
        sat = (1 << W[i]) - 1;
        ee = '0;
        for (int k = 0; k < 4; k++) begin
          ep[k] = ed && cnt[i][k] == 0;
          ee[k*16 +: 16] = 16'((cnt[i][k] > sat) ? sat : cnt[i][k]);
        end
        if (i == 0) begin
          ap = pass_a;
          ae = err_a;
          check("busy", {63'b0, busy_a}, {63'b0, eb});
          check("done", {63'b0, done_a}, {63'b0, ed});
        end else begin
          ap = pass_b;
          ae = '0;
          for (int k = 0; k < 4; k++) ae[k*16 +: 16] = {12'b0, err_b[k*4 +: 4]};
          check("busy_sat", {63'b0, busy_b}, {63'b0, eb});
          check("done_sat", {63'b0, done_b}, {63'b0, ed});
        end
        check(i == 0 ? "pass" : "pass_sat", {60'b0, ap}, {60'b0, ep});
        check(i == 0 ? "err_cnt" : "err_cnt_sat", ae, ee);
      end
    end
  end

  // One launch plus 24 driven edges; returns how many sampled cycles dut was busy.
  task automatic run(input bit settle_bad, input int c2n, input bit c0_last,
                     input bit c1_bad, input int restart_p, input int stop_p,
                     output int busy_cycles);
    logic [15:0] w0, w1, w2, w3;
    busy_cycles = 0;
    @(negedge clk);
    start = 1;
    adc_data = {PAD_GOOD, GOOD, GOOD, GOOD};
    for (int p = 1; p <= 24; p++) begin
      @(negedge clk);
      if (busy_a) busy_cycles++;
      if (p == stop_p) begin
        rst = 0;
        start = 0;
        return;
      end
      start = (p == restart_p);
      w0 = GOOD; w1 = GOOD; w2 = GOOD; w3 = PAD_GOOD;
      if (settle_bad && p <= S) begin
        w0 = 16'h1234; w1 = 16'h1234; w2 = 16'h1234; w3 = 16'h1234;
      end
      if (p > S && p <= S + c2n) w2 = 16'h0000;
      if (c0_last && p == S + 16) w0 = BAD0;
      if (c1_bad) w1 = 16'h0000;
      adc_data = {w3, w2, w1, w0};
    end
    @(negedge clk);
  endtask

  initial begin : stimulus
    int bc;
    rst = 0;
    start = 0;
    twoscomp = 0;
    testpattern = 14'h2A5A;
    adc_data = {4{16'h8000}};
    repeat (3) @(negedge clk);
    check("reset sample_out", sample_a, 64'h0);
    check("reset flags", {60'b0, vld_a, busy_a, done_a, 1'b0}, 64'h0);
    check("reset pass/err", {pass_a, err_a[59:0]}, 64'h0);

    rst = 1;
    @(negedge clk);
    check("unpack offset 8000", sample_a, 64'h0);
    check("vld after release", {63'b0, vld_a}, 64'h1);
    twoscomp = 1;
    @(negedge clk);
    check("unpack twos 8000", sample_a, {4{16'hE000}});
    twoscomp = 0;

    run(0, 0, 0, 0, 0, 0, bc);
    check("clean busy cycles", 64'(bc), 64'd20);
    check("clean done/pass", {59'b0, done_a, pass_a}, {59'b0, 1'b1, 4'hF});
    check("clean err_cnt", err_a, 64'h0);

    run(0, 5, 1, 0, 0, 0, bc);
    check("inject err_cnt2", 64'(err_a[47:32]), 64'd5);
    check("inject err_cnt0", 64'(err_a[15:0]), 64'd1);
    check("inject pass", {60'b0, pass_a}, {60'b0, 4'b1010});

    run(1, 0, 0, 0, 0, 0, bc);
    check("settle mask pass", {60'b0, pass_a}, {60'b0, 4'hF});
    check("settle mask err_cnt", err_a, 64'h0);

    run(0, 0, 0, 1, 0, 0, bc);
    check("sat err_cnt1", {60'b0, err_b[7:4]}, 64'd15);
    check("sat pass1", {63'b0, pass_b[1]}, 64'h0);
    check("unsat err_cnt1", 64'(err_a[31:16]), 64'd16);

    run(0, 0, 0, 0, S + 5, 0, bc);
    check("restart ignored busy", 64'(bc), 64'd20);
    check("restart ignored done", {63'b0, done_a}, 64'h1);

    run(0, 3, 0, 0, 0, S + 8, bc);
    @(negedge clk);
    check("midrun reset flags", {60'b0, vld_a, busy_a, done_a, 1'b0}, 64'h0);
    check("midrun reset pass/err", {pass_a, err_a[59:0]}, 64'h0);
    check("midrun reset sample", sample_a, 64'h0);
    rst = 1;
    @(negedge clk);

    run(0, 2, 0, 0, 0, 0, bc);
    check("post-reset err_cnt2", 64'(err_a[47:32]), 64'd2);
    start = 1;
    repeat (30) @(negedge clk);
    check("held start single launch", {63'b0, done_a}, 64'h1);
    start = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
